// File: rtl/qaddsub_pipe.sv
// Two-stage streaming sign-magnitude fixed-point adder/subtractor with valid/ready handshake.
// S1 captures signs, magnitudes and the magnitude compare; S2 holds the result.
module qaddsub_pipe #(
  parameter int unsigned Q   = 15,
  parameter int unsigned N   = 32,
  parameter bit          SAT = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sub,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_c,
  output logic         o_ovf
);

  localparam int unsigned MW = N - 1;

  if (N < 4 || Q >= N) begin : g_bad_param
    $error("qaddsub_pipe: need N >= 4 and Q < N");
  end

  logic          s1_valid_q;
  logic          s1_sa_q, s1_sb_q, s1_agtb_q;
  logic [MW-1:0] s1_ma_q, s1_mb_q;
  logic          s2_valid_q;
  logic [N-1:0]  s2_c_q;
  logic          s2_ovf_q;

  logic          s1_adv, s2_adv;
  logic [N-1:0]  sum_c;
  logic [MW-1:0] res_mag;
  logic          res_sign, res_ovf;

  assign s2_adv  = !s2_valid_q || i_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign o_ready = s1_adv;

  // Stage 1: split operands and fold the subtract into b's sign.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sa_q    <= 1'b0;
      s1_sb_q    <= 1'b0;
      s1_agtb_q  <= 1'b0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        s1_sa_q   <= i_a[N-1];
        s1_sb_q   <= i_b[N-1] ^ i_sub;
        s1_ma_q   <= i_a[MW-1:0];
        s1_mb_q   <= i_b[MW-1:0];
        s1_agtb_q <= (i_a[MW-1:0] > i_b[MW-1:0]);
      end
    end
  end

  // Result magnitude/sign from the registered operands.
  always_comb begin
    sum_c    = N'({1'b0, s1_ma_q}) + N'({1'b0, s1_mb_q});
    res_mag  = '0;
    res_sign = 1'b0;
    res_ovf  = 1'b0;
    if (s1_sa_q == s1_sb_q) begin
      res_sign = s1_sa_q;
      res_ovf  = sum_c[N-1];
      if (sum_c[N-1] && SAT) begin
        res_mag = '1;
      end else begin
        res_mag = sum_c[MW-1:0];
      end
    end else if (s1_agtb_q) begin
      res_sign = s1_sa_q;
      res_mag  = s1_ma_q - s1_mb_q;
    end else begin
      res_sign = s1_sb_q;
      res_mag  = s1_mb_q - s1_ma_q;
    end
    // Never emit negative zero.
    if (res_mag == '0) begin
      res_sign = 1'b0;
    end
  end

  // Stage 2: output register; holds while downstream stalls, ovf cleared on bubbles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q <= 1'b0;
      s2_c_q     <= '0;
      s2_ovf_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_c_q   <= {res_sign, res_mag};
        s2_ovf_q <= res_ovf;
      end else begin
        s2_ovf_q <= 1'b0;
      end
    end
  end

  assign o_valid = s2_valid_q;
  assign o_c     = s2_c_q;
  assign o_ovf   = s2_ovf_q;

endmodule

// File: tb/tb_qaddsub_pipe.sv
// Bench for qaddsub_pipe: directed table cases plus a randomized back-pressured stream,
// with saturating and wrapping instances driven in parallel against a signed-integer model.
module tb_qaddsub_pipe;

  localparam int unsigned N = 32;
  localparam longint MAXM = 64'sd2147483647;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
  } op_t;

  logic         clk, rst_n;
  logic         i_valid, i_ready, i_sub;
  logic [N-1:0] i_a, i_b;
  logic         o_ready, o_valid, o_ovf;
  logic [N-1:0] o_c;
  logic         w_ready, w_valid, w_ovf;
  logic [N-1:0] w_c;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  op_t exp_q[$];

  logic         prev_stall;
  logic [N-1:0] prev_c;
  logic         prev_ovf;

  qaddsub_pipe #(.Q(15), .N(N), .SAT(1'b1)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(o_valid), .i_ready(i_ready),
    .o_c(o_c), .o_ovf(o_ovf));

  qaddsub_pipe #(.Q(15), .N(N), .SAT(1'b0)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(w_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(w_valid), .i_ready(i_ready),
    .o_c(w_c), .o_ovf(w_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: signed integer sum, then clamp or wrap the magnitude; {ovf, c}.
  function automatic logic [N:0] model(input op_t op, input bit sat);
    longint va, vb, r, m;
    bit     ovf, neg;
    va = longint'(op.a[N-2:0]);
    vb = longint'(op.b[N-2:0]);
    if (op.a[N-1]) va = -va;
    if (op.b[N-1] ^ op.sub) vb = -vb;
    r   = va + vb;
    m   = (r < 0) ? -r : r;
    ovf = (m > MAXM);
    if (ovf) m = sat ? MAXM : (m - (MAXM + 1));
    neg = (r < 0) && (m != 0);
    return {ovf, neg, m[N-2:0]};
  endfunction

  // Scoreboard, output-stability and ovf-qualification checks, sampled mid-cycle.
  always @(negedge clk) begin
    logic [N:0] es, ew;
    op_t        e;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(o_valid), 64'd1);
        chk("stall_c", 64'(o_c), 64'(prev_c));
        chk("stall_ovf", 64'(o_ovf), 64'(prev_ovf));
      end
      if (!o_valid) chk("ovf_idle", 64'(o_ovf), 64'd0);
      if (i_valid && o_ready) exp_q.push_back('{a: i_a, b: i_b, sub: i_sub});
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("dup_result", 64'd1, 64'd0);
        end else begin
          e  = exp_q.pop_front();
          es = model(e, 1'b1);
          ew = model(e, 1'b0);
          chk("sb_sat", 64'({o_ovf, o_c}), 64'(es));
          chk("sb_wrap", 64'({w_ovf, w_c}), 64'(ew));
          pops++;
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_c     = o_c;
      prev_ovf   = o_ovf;
    end
  end

  // Single op into an empty pipe: checks latency 2 and the tabled results.
  task automatic send_one(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sub, input logic [N-1:0] ec, input logic eo,
                          input logic [N-1:0] ewc, input logic ewo);
    @(posedge clk); #1;
    i_a = a; i_b = b; i_sub = sub; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, 64'(o_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_lat2"}, 64'(o_valid), 64'd1);
    chk({tag, "_c"}, 64'(o_c), 64'(ec));
    chk({tag, "_ovf"}, 64'(o_ovf), 64'(eo));
    chk({tag, "_wc"}, 64'(w_c), 64'(ewc));
    chk({tag, "_wovf"}, 64'(w_ovf), 64'(ewo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, base, waited;
    bit acc, done;
    op_t op;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_sub = 1'b0; i_a = '0; i_b = '0;
    #12;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_c", 64'(o_c), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    #10 rst_n = 1'b1;

    send_one("add",    32'h00008000, 32'h00004000, 1'b0, 32'h0000C000, 1'b0, 32'h0000C000, 1'b0);
    send_one("subflip",32'h00004000, 32'h00008000, 1'b1, 32'h80004000, 1'b0, 32'h80004000, 1'b0);
    send_one("cancel", 32'h80008000, 32'h00008000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
    send_one("negzero",32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
    send_one("negz_a", 32'h80000000, 32'h00000005, 1'b0, 32'h00000005, 1'b0, 32'h00000005, 1'b0);
    send_one("ovf_pos",32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFE, 1'b1);
    send_one("ovf_neg",32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 1'b1);
    send_one("wrap0p", 32'h40000000, 32'h40000000, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b1);
    send_one("wrap0n", 32'hC0000000, 32'h40000000, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1);

    // Random stream: i_ready toggles 1010... with a 4-cycle stall in the middle.
    @(posedge clk); #1;
    base = pops; k = 0;
    i_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      op.a = $urandom; op.b = $urandom; op.sub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) op.b[N-2:0] = op.a[N-2:0];
      i_a = op.a; i_b = op.b; i_sub = op.sub; i_valid = 1'b1;
      done = 1'b0;
      for (int t = 0; t < 20 && !done; t++) begin
        @(negedge clk); acc = o_ready;
        @(posedge clk); #1;
        k++;
        i_ready = (k >= 8 && k < 12) ? 1'b0 : ((k % 2) == 0);
        done = acc;
      end
      if (!done) chk("accept_timeout", 64'd0, 64'd1);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    waited = 0;
    while ((exp_q.size() != 0 || o_valid) && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    chk("drain_timeout", 64'(waited < 20), 64'd1);
    chk("stream_count", 64'(pops - base), 64'd24);

    // Reset with two ops in flight and the output stalled.
    i_ready = 1'b0;
    i_a = 32'h00010000; i_b = 32'h00008000; i_sub = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1;
    i_a = 32'h7FFFFFFF; i_b = 32'h00000001; i_sub = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_c", 64'(o_c), 64'd0);
    chk("arst_ovf", 64'(o_ovf), 64'd0);
    @(negedge clk); #2;
    rst_n = 1'b1; i_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(o_ready), 64'd1);
    send_one("post_rst", 32'h00008000, 32'h80008000, 1'b1, 32'h00010000, 1'b0, 32'h00010000, 1'b0);
    @(posedge clk); #1;
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
